// File: rtl/l2_arb_pkg.sv
// Shared types for the two-port L2 bus arbiter: FSM states, grant type and port indices.
package l2_arb_pkg;

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_TURN} arb_state_e;
  typedef enum logic {GNT_RD, GNT_WR} gnt_type_e;

  localparam logic PORT_ICACHE = 1'b0;
  localparam logic PORT_DCACHE = 1'b1;

endpackage

// File: rtl/l2_bus_arbiter_2port_pick.sv
// Combinational round-robin pick: chooses the port (non-last-granted wins a tie) and the grant type
// (write beats read within a port). No state, zero latency, no backpressure.
module l2_arb_rr_pick
  import l2_arb_pkg::*;
(
  input  logic      [1:0] rd_req,
  input  logic      [1:0] wr_req,
  input  logic            last_granted,
  output logic            any_req,
  output logic            pick_port,
  output gnt_type_e       pick_type
);

  logic [1:0] port_req;

  assign port_req  = rd_req | wr_req;
  assign any_req   = |port_req;
  assign pick_port = (&port_req) ? ~last_granted : port_req[1];
  // Evict before fill: a pending write-back must leave before the refill lands.
  assign pick_type = wr_req[pick_port] ? GNT_WR : GNT_RD;

endmodule

// File: rtl/l2_bus_arbiter_2port.sv
// Two-port L2 bus arbiter: round-robin grant, 1-cycle request->grant from IDLE, bounded hold, 1-cycle turnaround.
// Optional L2_ARB_PERF_CNT_EN adds grant and contention counters.
module l2_bus_arbiter_2port
  import l2_arb_pkg::*;
#(
  parameter int NPORTS   = 2,
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NPORTS-1:0]      rd_req,
  input  logic [NPORTS-1:0]      wr_req,
  input  logic [NPORTS*32-1:0]   req_addr,
  input  logic [NPORTS*32-1:0]   req_wr_data,
  input  logic [NPORTS-1:0]      req_mem_en,
  input  logic [NPORTS-1:0]      req_mem_wr_en,
  output logic [NPORTS-1:0]      l2_bus_arbiter_rd_granted,
  output logic [NPORTS-1:0]      l2_bus_arbiter_wr_granted,
  output logic [31:0]            l2_mem_access_addr,
  output logic [31:0]            l2_mem_wr_data,
  output logic                   l2_mem_en,
  output logic                   l2_mem_wr_en,
  output logic                   hold_timeout
`ifdef L2_ARB_PERF_CNT_EN
  ,
  output logic [31:0]            grant_cnt_p0,
  output logic [31:0]            grant_cnt_p1,
  output logic [31:0]            contention_cnt
`endif
);

  arb_state_e        state;
  logic              gnt_port;
  gnt_type_e         gnt_type;
  logic              last_granted;
  logic [HOLD_W-1:0] hold_cnt;

  logic              any_req;
  logic              pick_port;
  gnt_type_e         pick_type;
  logic              gnt_req_bit;
  logic              hold_max;

  l2_arb_rr_pick u_pick (
    .rd_req       (rd_req),
    .wr_req       (wr_req),
    .last_granted (last_granted),
    .any_req      (any_req),
    .pick_port    (pick_port),
    .pick_type    (pick_type)
  );

  // The grant tracks only the request line it was issued for; a type change mid-grant ends it.
  assign gnt_req_bit = (gnt_type == GNT_WR) ? wr_req[gnt_port] : rd_req[gnt_port];
  assign hold_max    = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ARB_IDLE;
      gnt_port     <= PORT_ICACHE;
      gnt_type     <= GNT_RD;
      last_granted <= PORT_DCACHE;
      hold_cnt     <= '0;
      hold_timeout <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (any_req) begin
            state    <= ARB_GRANT;
            gnt_port <= pick_port;
            gnt_type <= pick_type;
            hold_cnt <= '0;
          end
        end
        ARB_GRANT: begin
          if (!gnt_req_bit || hold_max) begin
            state        <= ARB_TURN;
            last_granted <= gnt_port;
            if (gnt_req_bit) hold_timeout <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ARB_TURN: state <= ARB_IDLE;
        default:  state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    l2_bus_arbiter_rd_granted = '0;
    l2_bus_arbiter_wr_granted = '0;
    l2_mem_access_addr        = '0;
    l2_mem_wr_data            = '0;
    l2_mem_en                 = 1'b0;
    l2_mem_wr_en              = 1'b0;
    if (state == ARB_GRANT) begin
      if (gnt_type == GNT_WR) l2_bus_arbiter_wr_granted[gnt_port] = 1'b1;
      else                    l2_bus_arbiter_rd_granted[gnt_port] = 1'b1;
      l2_mem_access_addr = req_addr[{gnt_port, 5'd0} +: 32];
      l2_mem_wr_data     = req_wr_data[{gnt_port, 5'd0} +: 32];
      l2_mem_en          = req_mem_en[gnt_port];
      l2_mem_wr_en       = (gnt_type == GNT_WR) && req_mem_wr_en[gnt_port];
    end
  end

`ifdef L2_ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_cnt_p0   <= '0;
      grant_cnt_p1   <= '0;
      contention_cnt <= '0;
    end else if (state == ARB_IDLE) begin
      if (any_req) begin
        if (pick_port) grant_cnt_p1 <= grant_cnt_p1 + 32'd1;
        else           grant_cnt_p0 <= grant_cnt_p0 + 32'd1;
      end
      if (&(rd_req | wr_req)) contention_cnt <= contention_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l2_bus_arbiter_2port.sv
// Directed bench for l2_bus_arbiter_2port with an abstract ownership model checked every cycle.
module tb_l2_bus_arbiter_2port;

  localparam int MAX_HOLD = 16;

  logic        clk, rst;
  logic [1:0]  rd_req, wr_req, req_mem_en, req_mem_wr_en;
  logic [63:0] req_addr, req_wr_data;
  logic [1:0]  rd_g, wr_g;
  logic [31:0] l2_addr, l2_dat;
  logic        l2_en, l2_we, tmo;
`ifdef L2_ARB_PERF_CNT_EN
  logic [31:0] cnt_p0, cnt_p1, cnt_cont;
`endif

  l2_bus_arbiter_2port dut (
    .clk                       (clk),
    .rst                       (rst),
    .rd_req                    (rd_req),
    .wr_req                    (wr_req),
    .req_addr                  (req_addr),
    .req_wr_data               (req_wr_data),
    .req_mem_en                (req_mem_en),
    .req_mem_wr_en             (req_mem_wr_en),
    .l2_bus_arbiter_rd_granted (rd_g),
    .l2_bus_arbiter_wr_granted (wr_g),
    .l2_mem_access_addr        (l2_addr),
    .l2_mem_wr_data            (l2_dat),
    .l2_mem_en                 (l2_en),
    .l2_mem_wr_en              (l2_we),
    .hold_timeout              (tmo)
`ifdef L2_ARB_PERF_CNT_EN
    ,
    .grant_cnt_p0              (cnt_p0),
    .grant_cnt_p1              (cnt_p1),
    .contention_cnt            (cnt_cont)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, for how many cycles, and how many dead cycles remain before arbitration.
  int          m_owner;
  bit          m_wr;
  int          m_held;
  int          m_gap;
  int          m_last;
  bit          m_tmo;
  logic [31:0] m_cnt0, m_cnt1, m_cont;

  always @(posedge clk or posedge rst) begin
    bit r0, r1, rb;
    int ch;
    if (rst) begin
      m_owner = -1; m_wr = 0; m_held = 0; m_gap = 0; m_last = 1; m_tmo = 0;
      m_cnt0 = 0; m_cnt1 = 0; m_cont = 0;
    end else if (m_owner >= 0) begin
      rb = m_wr ? wr_req[m_owner] : rd_req[m_owner];
      if (!rb || m_held == MAX_HOLD) begin
        if (rb) m_tmo = 1;
        m_last  = m_owner;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      r0 = rd_req[0] | wr_req[0];
      r1 = rd_req[1] | wr_req[1];
      if (r0 && r1) begin
        m_cont++;
        ch = 1 - m_last;
      end else begin
        ch = r1 ? 1 : 0;
      end
      if (r0 || r1) begin
        m_owner = ch;
        m_wr    = wr_req[ch];
        m_held  = 1;
        if (ch == 0) m_cnt0++;
        else         m_cnt1++;
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0]  e_rd, e_wr;
    logic [31:0] e_addr, e_dat;
    logic        e_en, e_we;
    e_rd = '0; e_wr = '0; e_addr = '0; e_dat = '0; e_en = 1'b0; e_we = 1'b0;
    if (m_owner >= 0) begin
      if (m_wr) e_wr[m_owner] = 1'b1;
      else      e_rd[m_owner] = 1'b1;
      e_addr = req_addr[m_owner*32 +: 32];
      e_dat  = req_wr_data[m_owner*32 +: 32];
      e_en   = req_mem_en[m_owner];
      e_we   = m_wr & req_mem_wr_en[m_owner];
    end
    chk("cyc_rd_granted", 32'(rd_g), 32'(e_rd));
    chk("cyc_wr_granted", 32'(wr_g), 32'(e_wr));
    chk("cyc_addr", l2_addr, e_addr);
    chk("cyc_wr_data", l2_dat, e_dat);
    chk("cyc_mem_en", 32'(l2_en), 32'(e_en));
    chk("cyc_mem_wr_en", 32'(l2_we), 32'(e_we));
    chk("cyc_hold_timeout", 32'(tmo), 32'(m_tmo));
`ifdef L2_ARB_PERF_CNT_EN
    chk("cyc_grant_cnt_p0", cnt_p0, m_cnt0);
    chk("cyc_grant_cnt_p1", cnt_p1, m_cnt1);
    chk("cyc_contention", cnt_cont, m_cont);
`endif
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int order[$];
    int starts[$];
    bit prev;
    int n0, p1_start;

    rst = 1'b1;
    rd_req = '0; wr_req = '0; req_mem_en = '0; req_mem_wr_en = '0;
    req_addr = '0; req_wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_granted", 32'(rd_g), 32'h0);
    chk("reset_mem_en", 32'(l2_en), 32'h0);
    chk("reset_hold_timeout", 32'(tmo), 32'h0);
    step();
    rst = 1'b0;
    repeat (2) step();

    // Single read from port 1 held for 4 cycles.
    req_addr    = {32'h0000_1000, 32'h0000_0aa0};
    req_wr_data = {32'hdead_0001, 32'hbeef_0000};
    req_mem_en  = 2'b10;
    rd_req      = 2'b10;
    for (int i = 1; i <= 4; i++) begin
      step();
      if (i == 4) begin
        rd_req = '0;
        req_mem_en = '0;
      end
      @(negedge clk);
      chk("single_rd_gnt", 32'(rd_g), 32'h2);
      chk("single_wr_gnt", 32'(wr_g), 32'h0);
      chk("single_rd_addr", l2_addr, 32'h0000_1000);
    end
    step();
    @(negedge clk);
    chk("single_rd_turn", 32'(rd_g), 32'h0);
    repeat (3) step();

    // Request withdrawn the cycle its grant appears: one-cycle grant.
    wr_req = 2'b10;
    step();
    wr_req = '0;
    @(negedge clk);
    chk("short_wr_gnt", 32'(wr_g), 32'h2);
    step();
    @(negedge clk);
    chk("short_wr_released", 32'(wr_g), 32'h0);
    repeat (3) step();

    // Both ports reading; each drops in its 4th grant cycle and re-requests right after.
    prev = 0;
    for (int c = 0; c < 40; c++) begin
      step();
      rd_req = 2'b11;
      if (m_owner >= 0 && m_held == 4) rd_req[m_owner] = 1'b0;
      @(negedge clk);
      if (rd_g != 2'b00 && !prev) begin
        order.push_back(rd_g[1] ? 1 : 0);
        starts.push_back(c);
      end
      prev = |rd_g;
    end
    chk("rr_grant_count", 32'(order.size() >= 4), 32'h1);
    if (order.size() >= 4) begin
      chk("rr_order0", 32'(order[0]), 32'h0);
      chk("rr_order1", 32'(order[1]), 32'h1);
      chk("rr_order2", 32'(order[2]), 32'h0);
      chk("rr_order3", 32'(order[3]), 32'h1);
      chk("rr_period", 32'(starts[1] - starts[0]), 32'd6);
    end
    rd_req = '0;
    repeat (5) step();

    // Write beats read on the same port; changing type mid-grant ends the grant.
    req_addr      = {32'h0000_2000, 32'h0000_0bb0};
    rd_req        = 2'b10;
    wr_req        = 2'b10;
    req_mem_en    = 2'b10;
    req_mem_wr_en = 2'b10;
    step();
    @(negedge clk);
    chk("wrpri_wr_gnt", 32'(wr_g), 32'h2);
    chk("wrpri_rd_gnt", 32'(rd_g), 32'h0);
    chk("wrpri_wr_en", 32'(l2_we), 32'h1);
    step();
    req_mem_wr_en = '0;
    @(negedge clk);
    chk("wrpri_wr_en_follow", 32'(l2_we), 32'h0);
    step();
    wr_req = '0;
    @(negedge clk);
    chk("retype_still_wr", 32'(wr_g), 32'h2);
    step();
    @(negedge clk);
    chk("retype_turn_rd", 32'(rd_g), 32'h0);
    chk("retype_turn_wr", 32'(wr_g), 32'h0);
    step();
    step();
    rd_req = '0;
    @(negedge clk);
    chk("retype_regrant_rd", 32'(rd_g), 32'h2);
    repeat (3) step();

    // Port 0 stuck requesting: forced release after MAX_HOLD cycles, then port 1.
    req_mem_en = '0;
    rd_req = 2'b11;
    n0 = 0;
    p1_start = -1;
    for (int c = 0; c < 25; c++) begin
      step();
      @(negedge clk);
      if (rd_g == 2'b01) n0++;
      if (rd_g == 2'b10 && p1_start < 0) p1_start = c;
      if (c == 15) chk("tmo_before_release", 32'(tmo), 32'h0);
      if (c == 16) chk("tmo_after_release", 32'(tmo), 32'h1);
    end
    chk("tmo_hold_cycles", 32'(n0), 32'd16);
    chk("tmo_p1_start", 32'(p1_start), 32'd18);
    rd_req = '0;
    repeat (4) step();
    @(negedge clk);
    chk("tmo_sticky", 32'(tmo), 32'h1);

    // Read grant masks write strobe; async reset mid-grant; re-grant after reset.
    req_addr      = {32'h0000_4000, 32'h0000_3000};
    req_mem_en    = 2'b01;
    req_mem_wr_en = 2'b01;
    rd_req        = 2'b01;
    step();
    @(negedge clk);
    chk("mask_rd_gnt", 32'(rd_g), 32'h1);
    chk("mask_wr_en", 32'(l2_we), 32'h0);
    chk("mask_mem_en", 32'(l2_en), 32'h1);
    step();
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_rd_gnt", 32'(rd_g), 32'h0);
    chk("rst_mid_mem_en", 32'(l2_en), 32'h0);
    chk("rst_mid_addr", l2_addr, 32'h0);
    chk("rst_mid_tmo", 32'(tmo), 32'h0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("post_rst_rd_gnt", 32'(rd_g), 32'h1);
    chk("post_rst_wr_en", 32'(l2_we), 32'h0);
`ifdef L2_ARB_PERF_CNT_EN
    chk("post_rst_cnt_p0", cnt_p0, 32'd1);
    chk("post_rst_cnt_p1", cnt_p1, 32'd0);
`endif
    rd_req = '0;
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
